// File: rtl/capture_pkg.sv
// Shared types and helper functions for the multi-channel timestamp capture unit.
package capture_pkg;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } out_state_t;

    function automatic int chan_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Increment v by one, sticking at the all-ones value of a w-bit field.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
        logic [31:0] max_v;
        max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return (v >= max_v) ? max_v : v + 32'd1;
    endfunction

endpackage

// File: rtl/edge_sync.sv
// Multi-flop synchroniser for one asynchronous event line plus a one-cycle rising-edge pulse.
module edge_sync #(
    parameter int pSYNC = 2
) (
    input  logic iCLK,
    input  logic iRST_N,
    input  logic iD,
    output logic oRISE
);

    logic [pSYNC-1:0] sync_r;
    logic             prev_r;

    // Synchroniser chain and one-cycle history of the synchronised level
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            sync_r <= '0;
            prev_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[pSYNC-2:0], iD};
            prev_r <= sync_r[pSYNC-1];
        end
    end

    assign oRISE = sync_r[pSYNC-1] & ~prev_r;

endmodule

// File: rtl/capture_counter_array.sv
// N-channel timestamp capture: per-channel one-deep slots with miss counts,
// drained round-robin onto a single valid/ready record stream.
module capture_counter_array
    import capture_pkg::*;
#(
    parameter int pWIDTH      = 40,
    parameter int pCHANNELS   = 2,
    parameter int pSYNC       = 2,
    parameter int pMISS_WIDTH = 8
) (
    input  logic                                iCLK,
    input  logic                                iRST_N,
    input  logic                                iENABLE,
    input  logic                                iCLEAR,
    input  logic [pCHANNELS-1:0]                iEVENT,
    output logic                                oVALID,
    input  logic                                iREADY,
    output logic [chan_width(pCHANNELS)-1:0]    oCHANNEL,
    output logic [pWIDTH-1:0]                   oTIMESTAMP,
    output logic [pMISS_WIDTH-1:0]              oMISSED,
    output logic [pWIDTH-1:0]                   oCOUNTER,
    output logic [pCHANNELS-1:0]                oPENDING
);

    localparam int            CW      = chan_width(pCHANNELS);
    localparam logic [CW-1:0] LAST_CH = CW'(pCHANNELS - 1);

    logic [pWIDTH-1:0]      counter_r;
    out_state_t             state_r;
    out_state_t             state_nxt_s;
    logic [CW-1:0]          ptr_r;
    logic [pCHANNELS-1:0]   rise_s;
    logic [pCHANNELS-1:0]   hit_s;
    logic [pCHANNELS-1:0]   gnt_s;
    logic [pCHANNELS-1:0]   full_s;
    logic [pWIDTH-1:0]      ts_s   [pCHANNELS];
    logic [pMISS_WIDTH-1:0] miss_s [pCHANNELS];
    logic                   any_full_s;
    logic                   take_s;
    logic                   load_s;
    logic                   hi_found_s;
    logic [CW-1:0]          hi_idx_s;
    logic [CW-1:0]          lo_idx_s;
    logic [CW-1:0]          grant_idx_s;

    // Free-running timestamp counter
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            counter_r <= '0;
        end else if (iCLEAR) begin
            counter_r <= '0;
        end else if (iENABLE) begin
            counter_r <= counter_r + pWIDTH'(1);
        end
    end

    for (genvar c = 0; c < pCHANNELS; c++) begin : g_ch
        logic                   slot_full_r;
        logic [pWIDTH-1:0]      slot_ts_r;
        logic [pMISS_WIDTH-1:0] slot_miss_r;

        edge_sync #(.pSYNC(pSYNC)) u_sync (
            .iCLK  (iCLK),
            .iRST_N(iRST_N),
            .iD    (iEVENT[c]),
            .oRISE (rise_s[c])
        );

        assign hit_s[c] = rise_s[c] & iENABLE;
        assign gnt_s[c] = load_s & (grant_idx_s == CW'(c));

        // Slot: first hit keeps its timestamp; a grant in the same cycle as a hit refills it
        always_ff @(posedge iCLK or negedge iRST_N) begin
            if (!iRST_N) begin
                slot_full_r <= 1'b0;
                slot_ts_r   <= '0;
                slot_miss_r <= '0;
            end else if (iCLEAR) begin
                slot_full_r <= 1'b0;
                slot_ts_r   <= '0;
                slot_miss_r <= '0;
            end else if (hit_s[c]) begin
                if (!slot_full_r || gnt_s[c]) begin
                    slot_full_r <= 1'b1;
                    slot_ts_r   <= counter_r;
                    slot_miss_r <= '0;
                end else begin
                    slot_miss_r <= pMISS_WIDTH'(sat_inc(32'(slot_miss_r), pMISS_WIDTH));
                end
            end else if (gnt_s[c]) begin
                slot_full_r <= 1'b0;
            end
        end

        assign full_s[c] = slot_full_r;
        assign ts_s[c]   = slot_ts_r;
        assign miss_s[c] = slot_miss_r;
    end

    // Round-robin pick: lowest full channel at/after the pointer, else lowest full overall
    always_comb begin
        hi_found_s = 1'b0;
        hi_idx_s   = '0;
        lo_idx_s   = '0;
        for (int j = pCHANNELS - 1; j >= 0; j--) begin
            hi_found_s = hi_found_s | (full_s[j] & (CW'(j) >= ptr_r));
            hi_idx_s   = (full_s[j] && (CW'(j) >= ptr_r)) ? CW'(j) : hi_idx_s;
            lo_idx_s   = full_s[j] ? CW'(j) : lo_idx_s;
        end
        any_full_s  = |full_s;
        grant_idx_s = hi_found_s ? hi_idx_s : lo_idx_s;
        take_s      = (state_r == ST_IDLE) | iREADY;
        load_s      = take_s & any_full_s;
    end

    // Output stage next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE:    state_nxt_s = any_full_s ? ST_PRESENT : ST_IDLE;
            ST_PRESENT: state_nxt_s = (iREADY && !any_full_s) ? ST_IDLE : ST_PRESENT;
            default:    state_nxt_s = ST_IDLE;
        endcase
    end

    // Output stage registers, arbiter pointer and record payload
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_r    <= ST_IDLE;
            ptr_r      <= '0;
            oVALID     <= 1'b0;
            oCHANNEL   <= '0;
            oTIMESTAMP <= '0;
            oMISSED    <= '0;
        end else if (iCLEAR) begin
            state_r    <= ST_IDLE;
            ptr_r      <= '0;
            oVALID     <= 1'b0;
            oCHANNEL   <= '0;
            oTIMESTAMP <= '0;
            oMISSED    <= '0;
        end else begin
            state_r <= state_nxt_s;
            oVALID  <= (state_nxt_s == ST_PRESENT);
            if (load_s) begin
                ptr_r      <= (grant_idx_s == LAST_CH) ? '0 : grant_idx_s + CW'(1);
                oCHANNEL   <= grant_idx_s;
                oTIMESTAMP <= ts_s[grant_idx_s];
                oMISSED    <= miss_s[grant_idx_s];
            end
        end
    end

    assign oCOUNTER = counter_r;
    assign oPENDING = full_s;

endmodule

// File: tb/tb_capture_counter_array.sv
// Scoreboard bench for capture_counter_array: expected records are queued as events are driven.
module tb_capture_counter_array;

    localparam int W    = 8;
    localparam int NCH  = 2;
    localparam int SYNC = 2;
    localparam int MW   = 2;

    typedef struct packed {
        logic [0:0]    ch;
        logic [W-1:0]  ts;
        logic [MW-1:0] miss;
    } rec_t;

    logic           iCLK = 1'b0;
    logic           iRST_N;
    logic           iENABLE;
    logic           iCLEAR;
    logic           iREADY;
    logic [NCH-1:0] iEVENT;
    logic           oVALID;
    logic [0:0]     oCHANNEL;
    logic [W-1:0]   oTIMESTAMP;
    logic [MW-1:0]  oMISSED;
    logic [W-1:0]   oCOUNTER;
    logic [NCH-1:0] oPENDING;

    logic [W-1:0]   model_cnt;
    logic [W-1:0]   held_cnt;
    rec_t           exp_q[$];
    rec_t           mon_e;
    int             n_checks = 0;
    int             n_pass   = 0;

    capture_counter_array #(
        .pWIDTH     (W),
        .pCHANNELS  (NCH),
        .pSYNC      (SYNC),
        .pMISS_WIDTH(MW)
    ) dut (
        .iCLK      (iCLK),
        .iRST_N    (iRST_N),
        .iENABLE   (iENABLE),
        .iCLEAR    (iCLEAR),
        .iEVENT    (iEVENT),
        .oVALID    (oVALID),
        .iREADY    (iREADY),
        .oCHANNEL  (oCHANNEL),
        .oTIMESTAMP(oTIMESTAMP),
        .oMISSED   (oMISSED),
        .oCOUNTER  (oCOUNTER),
        .oPENDING  (oPENDING)
    );

    always #5 iCLK = ~iCLK;

    // Reference counter
    always @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N)      model_cnt <= '0;
        else if (iCLEAR)  model_cnt <= '0;
        else if (iENABLE) model_cnt <= model_cnt + W'(1);
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Expected timestamp: counter value now plus the synchroniser latency.
    task automatic push(input int ch, input int miss);
        rec_t r;
        r.ch   = 1'(ch);
        r.ts   = model_cnt + W'(SYNC);
        r.miss = MW'(miss);
        exp_q.push_back(r);
    endtask

    task automatic pulse(input int ch, input int hi, input int lo);
        iEVENT[ch] = 1'b1;
        repeat (hi) @(negedge iCLK);
        iEVENT[ch] = 1'b0;
        repeat (lo) @(negedge iCLK);
    endtask

    task automatic wait_cnt(input logic [W-1:0] target);
        int n = 0;
        while (model_cnt !== target && n < 600) begin
            @(negedge iCLK);
            n++;
        end
        check_val("wait_cnt", 64'(model_cnt), 64'(target));
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge iCLK);
            n++;
        end
        check_val(tag, 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: compare each handshaken record with the head of the scoreboard
    always @(negedge iCLK) begin
        #1;
        if (iRST_N && oVALID && iREADY) begin
            check_val("sb_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check_val("sb_channel",   64'(oCHANNEL),   64'(mon_e.ch));
                check_val("sb_timestamp", 64'(oTIMESTAMP), 64'(mon_e.ts));
                check_val("sb_missed",    64'(oMISSED),    64'(mon_e.miss));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        iRST_N = 1'b0; iENABLE = 1'b1; iCLEAR = 1'b0; iREADY = 1'b1; iEVENT = '0;
        repeat (2) @(negedge iCLK);
        check_val("rst_valid",   64'(oVALID),     64'd0);
        check_val("rst_counter", 64'(oCOUNTER),   64'd0);
        check_val("rst_pending", 64'(oPENDING),   64'd0);
        check_val("rst_channel", 64'(oCHANNEL),   64'd0);
        check_val("rst_ts",      64'(oTIMESTAMP), 64'd0);
        check_val("rst_missed",  64'(oMISSED),    64'd0);
        iRST_N = 1'b1;

        // Single capture: rise before edge 100 -> timestamp 101, valid after edge 103
        wait_cnt(W'(99));
        push(0, 0);
        iEVENT[0] = 1'b1;
        repeat (3) @(posedge iCLK);
        #1;
        check_val("s1_valid_early", 64'(oVALID),   64'd0);
        check_val("s1_pending",     64'(oPENDING), 64'd1);
        @(posedge iCLK);
        #1;
        check_val("s1_valid_rise", 64'(oVALID),   64'd1);
        check_val("s1_counter",    64'(oCOUNTER), 64'd103);
        @(negedge iCLK);
        iEVENT[0] = 1'b0;
        drain("s1_drain");

        // Missed edges on ch1 while the output stage is stalled
        iREADY = 1'b0;
        push(0, 0);
        pulse(0, 3, 4);
        push(1, 2);
        for (int e = 0; e < 3; e++) pulse(1, 3, 7);
        check_val("s2_pending",    64'(oPENDING),   64'd2);
        check_val("s2_valid_hold", 64'(oVALID),     64'd1);
        check_val("s2_hold_ch",    64'(oCHANNEL),   64'd0);
        check_val("s2_hold_ts",    64'(oTIMESTAMP), 64'(exp_q[0].ts));
        iREADY = 1'b1;
        drain("s2_drain");
        check_val("s2_pend_clear", 64'(oPENDING), 64'd0);

        // Miss count saturates at 3
        iREADY = 1'b0;
        push(0, 0);
        pulse(0, 3, 4);
        push(1, 3);
        for (int e = 0; e < 7; e++) pulse(1, 2, 2);
        repeat (3) @(negedge iCLK);
        check_val("s2_sat_pending", 64'(oPENDING), 64'd2);
        iREADY = 1'b1;
        drain("s2_sat_drain");

        // Simultaneous events, then again after the pointer moved to ch1
        iEVENT = 2'b11;
        push(0, 0);
        push(1, 0);
        repeat (3) @(negedge iCLK);
        iEVENT = '0;
        drain("s3_drain_a");
        push(0, 0);
        pulse(0, 3, 4);
        drain("s3_drain_b");
        iEVENT = 2'b11;
        push(1, 0);
        push(0, 0);
        repeat (5) @(posedge iCLK);
        #1;
        check_val("s3_back2back_v",  64'(oVALID),   64'd1);
        check_val("s3_back2back_ch", 64'(oCHANNEL), 64'd0);
        @(negedge iCLK);
        iEVENT = '0;
        drain("s3_drain_c");

        // Counter wrap: timestamps 255 then 0
        wait_cnt(W'(253));
        iEVENT[0] = 1'b1;
        push(0, 0);
        @(negedge iCLK);
        iEVENT[1] = 1'b1;
        push(1, 0);
        repeat (3) @(negedge iCLK);
        iEVENT = '0;
        drain("s4_drain");

        // Edge on ch0 in the same cycle as its grant
        iREADY = 1'b0;
        push(1, 0);
        pulse(1, 3, 4);
        push(0, 0);
        pulse(0, 3, 4);
        check_val("s5_pending", 64'(oPENDING), 64'd1);
        iEVENT[0] = 1'b1;
        push(0, 0);
        @(negedge iCLK);
        @(negedge iCLK);
        iREADY = 1'b1;
        @(negedge iCLK);
        iEVENT[0] = 1'b0;
        drain("s5_drain");

        // Disabled: counter holds and edges are discarded
        iENABLE = 1'b0;
        held_cnt = model_cnt;
        pulse(0, 3, 4);
        check_val("dis_counter", 64'(oCOUNTER), 64'(held_cnt));
        check_val("dis_pending", 64'(oPENDING), 64'd0);
        check_val("dis_valid",   64'(oVALID),   64'd0);
        iENABLE = 1'b1;

        // Asynchronous reset during a stalled transfer
        iREADY = 1'b0;
        pulse(0, 3, 4);
        check_val("s6_valid", 64'(oVALID), 64'd1);
        #2 iRST_N = 1'b0;
        #1;
        check_val("s6_rst_valid", 64'(oVALID),   64'd0);
        check_val("s6_rst_cnt",   64'(oCOUNTER), 64'd0);
        @(negedge iCLK);
        iRST_N = 1'b1;

        // Clear with two full slots and a record in flight
        pulse(0, 3, 4);
        pulse(0, 3, 4);
        pulse(1, 3, 4);
        check_val("s6_two_full", 64'(oPENDING), 64'd3);
        iCLEAR = 1'b1;
        @(posedge iCLK);
        #1;
        check_val("s6_clr_pending", 64'(oPENDING), 64'd0);
        check_val("s6_clr_valid",   64'(oVALID),   64'd0);
        check_val("s6_clr_counter", 64'(oCOUNTER), 64'd0);
        @(negedge iCLK);
        iCLEAR = 1'b0;
        @(posedge iCLK);
        #1;
        check_val("s6_restart", 64'(oCOUNTER), 64'd1);
        @(negedge iCLK);

        // Pointer was cleared, so ch0 wins again
        iREADY = 1'b1;
        iEVENT = 2'b11;
        push(0, 0);
        push(1, 0);
        repeat (3) @(negedge iCLK);
        iEVENT = '0;
        drain("s6_post_clear");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
